serial_to_parallel_rx: RTL

//  Receive end of the team's 4-bit serial link: collects a bit-serial stream (LSB first by

---
 rtl/serial_link_pkg.sv | 18 +
 rtl/serial_to_parallel_rx_holding.sv | 56 +++++
 rtl/serial_to_parallel_rx.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// +--------------------------------------------------------------------+
// | serial_link_pkg: shared types/constants for the 4-bit serial link   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package serial_link_pkg;

    localparam int SER_WIDTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_to_parallel_rx_holding.sv
// +--------------------------------------------------------------------+
// | rx_out_holding_reg: one-word valid/ready output register with       |
// | overrun detect. Rev 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rx_out_holding_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_i,
    input  logic             complete_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             load;

    always_comb begin
        load      = complete_i & (~valid_q | ready_i);
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = complete_i & valid_q & ~ready_i;
        if (load) begin
            data_d  = word_i;
            valid_d = 1'b1;
        end else if (valid_q & ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel_rx.sv
// +--------------------------------------------------------------------+
// | serial_to_parallel_rx: bit-serial to WIDTH-bit word receiver with   |
// | valid/ready holding register. Rev 1.0                               |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_to_parallel_rx
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             serial_valid_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             parallel_valid_o,
    input  logic             parallel_ready_i,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_nxt;
    logic             busy_q;
    logic             accept;
    logic             complete;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shift_nxt = {serial_i, shift_q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shift_nxt = {shift_q[WIDTH-2:0], serial_i};
        end
    endgenerate

    assign accept   = serial_valid_i & ~clear_i;
    assign complete = accept & (cnt_q == LAST_CNT);

    // clear_i has priority: a bit presented in the clear cycle is dropped
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (serial_valid_i) begin
            shift_d = shift_nxt;
            cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: if (accept)              state_d = RX_RECV;
            RX_RECV: if (clear_i || complete) state_d = RX_IDLE;
            default:                          state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            busy_q  <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

    rx_out_holding_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .word_i    (shift_nxt),
        .complete_i(complete),
        .ready_i   (parallel_ready_i),
        .data_o    (parallel_o),
        .valid_o   (parallel_valid_o),
        .overrun_o (overrun_o)
    );

endmodule

`default_nettype wire
